// File: rtl/alu_exec_pipe_if.sv
// rtl/alu_exec_pipe_if.sv - operand/result handshake bundle for alu_exec_pipe
//
// Purpose: groups the operand transfer channel and the result delivery
// channel of the execute unit.
// Ports (signals):
//   in_valid, in_ready, SrcA, SrcB, ALUControl      - operand channel
//   out_valid, out_ready, Result, Zero, Negative,
//   Carry, Overflow, Illegal                         - result channel
//   err_count                                        - illegal-op counter
// Modports: master = issue/downstream side, slave = execute unit.

interface alu_exec_pipe_if #(
    parameter int WIDTH = 32,
    parameter int ERRW  = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] SrcA;
    logic [WIDTH-1:0] SrcB;
    logic [2:0]       ALUControl;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Result;
    logic             Zero;
    logic             Negative;
    logic             Carry;
    logic             Overflow;
    logic             Illegal;
    logic [ERRW-1:0]  err_count;

    modport master (
        output in_valid, SrcA, SrcB, ALUControl, out_ready,
        input  in_ready, out_valid, Result, Zero, Negative, Carry, Overflow,
               Illegal, err_count
    );

    modport slave (
        input  in_valid, SrcA, SrcB, ALUControl, out_ready,
        output in_ready, out_valid, Result, Zero, Negative, Carry, Overflow,
               Illegal, err_count
    );
endinterface

// File: rtl/alu_exec_pipe.sv
// rtl/alu_exec_pipe.sv - two-stage pipelined ALU execute unit with valid/ready
//
// Purpose: S1 captures operands and ALUControl, S2 holds the registered
// result and flags. Both stages stall under back-pressure and are killed by
// flush. err_count saturates and counts delivered illegal-code results.
// Ports:
//   clk    - rising-edge clock
//   rst    - asynchronous active-low reset
//   flush  - synchronous kill of both stages; blocks input that cycle
//   bus    - alu_exec_pipe_if.slave (operand and result channels)

module alu_exec_pipe #(
    parameter int WIDTH = 32,
    parameter int ERRW  = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           flush,
    alu_exec_pipe_if.slave bus
);
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_SLT = 3'b101;

    // Stage 1: captured operands
    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_a_q, s1_b_q;
    logic [2:0]       s1_op_q;

    // Stage 2: registered result and flags
    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] result_q;
    logic             zero_q, neg_q, carry_q, ovf_q, ill_q;

    logic [ERRW-1:0]  err_q, err_d;

    logic s2_adv, s1_adv, in_fire, s1_to_s2, out_fire;

    always_comb begin
        s2_adv   = !s2_valid_q || bus.out_ready;
        s1_adv   = !s1_valid_q || s2_adv;
        in_fire  = bus.in_valid && s1_adv && !flush;
        s1_to_s2 = s1_valid_q && s2_adv && !flush;
        out_fire = s2_valid_q && bus.out_ready;
    end

    // Combinational ALU on S1 contents
    logic             sub_c;
    logic [WIDTH-1:0] bx_c;
    logic [WIDTH:0]   sum_c;
    logic             add_ovf_c;
    logic [WIDTH-1:0] res_c;
    logic             carry_c, ovf_c, ill_c;

    always_comb begin
        sub_c     = (s1_op_q == OP_SUB) || (s1_op_q == OP_SLT);
        bx_c      = sub_c ? ~s1_b_q : s1_b_q;
        sum_c     = {1'b0, s1_a_q} + {1'b0, bx_c} + (WIDTH+1)'(sub_c);
        // Operands of equal sign producing a result of the other sign
        add_ovf_c = (s1_a_q[WIDTH-1] == bx_c[WIDTH-1]) &&
                    (sum_c[WIDTH-1] != s1_a_q[WIDTH-1]);
        res_c     = '0;
        carry_c   = 1'b0;
        ovf_c     = 1'b0;
        ill_c     = 1'b0;
        case (s1_op_q)
            OP_ADD, OP_SUB: begin
                res_c   = sum_c[WIDTH-1:0];
                carry_c = sum_c[WIDTH];
                ovf_c   = add_ovf_c;
            end
            OP_AND: res_c = s1_a_q & s1_b_q;
            OP_OR:  res_c = s1_a_q | s1_b_q;
            OP_SLT: begin
                // Signed less-than is N xor V of A - B
                res_c   = {{(WIDTH-1){1'b0}}, sum_c[WIDTH-1] ^ add_ovf_c};
                carry_c = sum_c[WIDTH];
                ovf_c   = add_ovf_c;
            end
            default: ill_c = 1'b1;
        endcase
    end

    always_comb begin
        if (flush) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
        end else begin
            s1_valid_d = in_fire || (s1_valid_q && !s2_adv);
            s2_valid_d = s1_to_s2 || (s2_valid_q && !bus.out_ready);
        end
        err_d = err_q;
        // Counting follows the output handshake even in a flush cycle
        if (out_fire && ill_q && (err_q != '1)) begin
            err_d = err_q + ERRW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_op_q    <= OP_ADD;
            s2_valid_q <= 1'b0;
            result_q   <= '0;
            zero_q     <= 1'b1;
            neg_q      <= 1'b0;
            carry_q    <= 1'b0;
            ovf_q      <= 1'b0;
            ill_q      <= 1'b0;
            err_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            err_q      <= err_d;
            if (in_fire) begin
                s1_a_q  <= bus.SrcA;
                s1_b_q  <= bus.SrcB;
                s1_op_q <= bus.ALUControl;
            end
            if (s1_to_s2) begin
                result_q <= res_c;
                zero_q   <= (res_c == '0);
                neg_q    <= res_c[WIDTH-1];
                carry_q  <= carry_c;
                ovf_q    <= ovf_c;
                ill_q    <= ill_c;
            end
        end
    end

    assign bus.in_ready  = s1_adv && !flush;
    assign bus.out_valid = s2_valid_q;
    assign bus.Result    = result_q;
    assign bus.Zero      = zero_q;
    assign bus.Negative  = neg_q;
    assign bus.Carry     = carry_q;
    assign bus.Overflow  = ovf_q;
    assign bus.Illegal   = ill_q;
    assign bus.err_count = err_q;
endmodule

// File: tb/tb_alu_exec_pipe.sv
// tb/tb_alu_exec_pipe.sv - directed self-checking bench for alu_exec_pipe

module tb_alu_exec_pipe;
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_SLT = 3'b101;
    localparam logic [2:0] OP_BAD = 3'b110;

    logic clk;
    logic rst;
    logic flush;

    alu_exec_pipe_if #(.WIDTH(32), .ERRW(8)) bus ();
    alu_exec_pipe_if #(.WIDTH(32), .ERRW(2)) bus2 ();

    alu_exec_pipe #(.WIDTH(32), .ERRW(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    alu_exec_pipe #(.WIDTH(32), .ERRW(2)) dut2 (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [4:0] flags();
        return {bus.Zero, bus.Negative, bus.Carry, bus.Overflow, bus.Illegal};
    endfunction

    // Called at posedge+1 with an empty pipeline; exp_f = {Z,N,C,V,I}
    task automatic run_single(input string tag, input logic [2:0] op,
                              input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] exp_res, input logic [4:0] exp_f);
        bus.ALUControl = op;
        bus.SrcA       = a;
        bus.SrcB       = b;
        bus.in_valid   = 1'b1;
        bus.out_ready  = 1'b1;
        check({tag, "_rdy"}, bus.in_ready, 1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check({tag, "_lat1"}, bus.out_valid, 0);
        @(posedge clk); #1;
        check({tag, "_valid"}, bus.out_valid, 1);
        check({tag, "_res"}, bus.Result, exp_res);
        check({tag, "_flags"}, flags(), exp_f);
        @(posedge clk); #1;
        check({tag, "_done"}, bus.out_valid, 0);
    endtask

    // Leaves an illegal op in S2 and an ADD in S1, out_ready low
    task automatic fill_two();
        bus.out_ready  = 1'b0;
        bus.in_valid   = 1'b1;
        bus.ALUControl = OP_BAD;
        bus.SrcA       = 32'd7;
        bus.SrcB       = 32'd9;
        @(posedge clk); #1;
        bus.ALUControl = OP_ADD;
        @(posedge clk); #1;
    endtask

    logic [31:0] bp_exp [6];
    logic [3:0]  or_pat;
    int          tx, rx;
    logic [31:0] held;
    bit          held_v;

    initial begin
        bp_exp = '{32'h11, 32'h12, 32'h13, 32'h14, 32'h15, 32'h16};
        or_pat = 4'b1001;
        rst = 1'b0;
        flush = 1'b0;
        bus.in_valid = 1'b0; bus.SrcA = '0; bus.SrcB = '0;
        bus.ALUControl = OP_ADD; bus.out_ready = 1'b1;
        bus2.in_valid = 1'b0; bus2.SrcA = '0; bus2.SrcB = '0;
        bus2.ALUControl = OP_ADD; bus2.out_ready = 1'b1;

        // Reset state
        #12;
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_result", bus.Result, 0);
        check("rst_flags", flags(), 5'b10000);
        check("rst_err", bus.err_count, 0);
        flush = 1'b1; #1;
        check("rst_flush_rdy", bus.in_ready, 0);
        flush = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // Single operations
        run_single("add_ovf", OP_ADD, 32'h7FFFFFFF, 32'h1, 32'h80000000, 5'b01010);
        run_single("sub_eq", OP_SUB, 32'd5, 32'd5, 32'h0, 5'b10100);
        run_single("slt_m1_1", OP_SLT, 32'hFFFFFFFF, 32'h1, 32'h1, 5'b00100);
        run_single("slt_1_m1", OP_SLT, 32'h1, 32'hFFFFFFFF, 32'h0, 5'b10000);
        run_single("slt_min_1", OP_SLT, 32'h80000000, 32'h1, 32'h1, 5'b00110);
        run_single("and", OP_AND, 32'hF0F0, 32'h0FF0, 32'h00F0, 5'b00000);
        run_single("or", OP_OR, 32'hF0F0, 32'h0FF0, 32'hFFF0, 5'b00000);

        // Illegal codes
        for (int i = 0; i < 3; i++) begin
            run_single("illegal", OP_BAD, 32'h1234, 32'h5678, 32'h0, 5'b10001);
        end
        check("err_three", bus.err_count, 3);

        // Saturation on the narrow counter
        bus2.ALUControl = OP_BAD;
        bus2.in_valid   = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        bus2.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("err_sat", bus2.err_count, 3);

        // Back-pressure stream of six ADDs
        tx = 0; rx = 0; held_v = 1'b0; held = '0;
        for (int k = 0; k < 60 && rx < 6; k++) begin
            bus.out_ready  = or_pat[k % 4];
            bus.in_valid   = (tx < 6);
            bus.ALUControl = OP_ADD;
            bus.SrcA       = 32'(tx + 1);
            bus.SrcB       = 32'h10;
            @(negedge clk);
            check("bp_in_ready", bus.in_ready, !((tx - rx) == 2 && !bus.out_ready));
            if (held_v) check("bp_hold", bus.Result, held);
            held_v = bus.out_valid && !bus.out_ready;
            held   = bus.Result;
            if (bus.out_valid && bus.out_ready) begin
                check("bp_order", bus.Result, bp_exp[rx]);
                rx++;
            end
            if (bus.in_valid && bus.in_ready) tx++;
            @(posedge clk); #1;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        check("bp_count", rx, 6);
        check("bp_drain", bus.out_valid, 0);

        // Flush with both stages full, no output handshake
        fill_two();
        bus.ALUControl = OP_OR;
        flush = 1'b1;
        @(negedge clk);
        check("fl_a_in_ready", bus.in_ready, 0);
        check("fl_a_full", {bus.out_valid, bus.Illegal}, 2'b11);
        @(posedge clk); #1;
        flush = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        check("fl_a_out_valid", bus.out_valid, 0);
        repeat (3) @(posedge clk);
        #1;
        check("fl_a_gone", bus.out_valid, 0);
        check("fl_a_err", bus.err_count, 3);

        // Flush while the illegal result is handed off
        fill_two();
        bus.ALUControl = OP_OR;
        bus.out_ready  = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        check("fl_b_in_ready", bus.in_ready, 0);
        @(posedge clk); #1;
        flush = 1'b0;
        bus.in_valid = 1'b0;
        check("fl_b_out_valid", bus.out_valid, 0);
        repeat (3) @(posedge clk);
        #1;
        check("fl_b_gone", bus.out_valid, 0);
        check("fl_b_err", bus.err_count, 4);

        // Asynchronous reset mid-stream
        bus.out_ready  = 1'b1;
        bus.in_valid   = 1'b1;
        bus.ALUControl = OP_ADD;
        bus.SrcA       = 32'd100;
        bus.SrcB       = 32'd1;
        @(posedge clk);
        @(posedge clk); #3;
        check("mid_pre_valid", bus.out_valid, 1);
        rst = 1'b0; #1;
        bus.in_valid = 1'b0;
        check("mid_out_valid", bus.out_valid, 0);
        check("mid_result", bus.Result, 0);
        check("mid_flags", flags(), 5'b10000);
        check("mid_err", bus.err_count, 0);
        check("mid_in_ready", bus.in_ready, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("mid_no_out", bus.out_valid, 0);
        run_single("post_rst", OP_ADD, 32'd2, 32'd3, 32'd5, 5'b00000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=0x0 exp=0x1");
        $fatal(1, "timeout");
    end
endmodule
